// File: rtl/color_sel_encoder.sv
// color_sel_encoder: turns two raw push-buttons into a 2-bit colour-select code.
// Each button is synchronized, then debounced. A debounced 0->1 edge is a press event.
// Presses step the code forward (next) or backward (prev) modulo 4.
// A synchronous load overrides any press in the same cycle.
//
// Ports
//   clk_i       clock; all state updates on its rising edge
//   rst_ni      asynchronous active-low reset
//   btn_next_i  raw button, asynchronous, active-high; steps code forward
//   btn_prev_i  raw button, asynchronous, active-high; steps code backward
//   load_i      synchronous load strobe for code_i
//   code_i      value loaded when load_i is high
//   code_o      registered code: 00 white, 01 red, 10 green, 11 yellow
//   changed_o   registered one-cycle pulse in the first cycle code_o shows a new value
module color_sel_encoder #(
  parameter int unsigned DB_CNT = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_next_i,
  input  logic       btn_prev_i,
  input  logic       load_i,
  input  logic [1:0] code_i,
  output logic [1:0] code_o,
  output logic       changed_o
);

  localparam int unsigned CntW = $clog2(DB_CNT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CNT - 1);

  // Bit 0 is the next button, bit 1 the prev button.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [1:0]      db_prev_q;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic [1:0]      press;
  logic [1:0]      code_q, code_d;
  logic            changed_q, changed_d;

  // Debounce: count consecutive mismatch cycles; accept on the DB_CNT-th one.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level; release produces nothing.
  assign press = db_q & ~db_prev_q;

  always_comb begin
    code_d = code_q;
    if (load_i) begin
      code_d = code_i;
    end else begin
      case (press)
        2'b01:   code_d = code_q + 2'd1;
        2'b10:   code_d = code_q - 2'd1;
        default: code_d = code_q;  // none, or both cancel
      endcase
    end
    changed_d = (code_d != code_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      code_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_prev_i, btn_next_i};
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      code_q    <= code_d;
      changed_q <= changed_d;
    end
  end

  assign code_o    = code_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_color_sel_encoder.sv
// Self-checking bench for color_sel_encoder with DB_CNT = 4.
module tb_color_sel_encoder;

  localparam int unsigned DB = 4;
  localparam int MaxE = 20000;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       btn_next_i = 1'b0;
  logic       btn_prev_i = 1'b0;
  logic       load_i = 1'b0;
  logic [1:0] code_i = 2'b00;
  logic [1:0] code_o;
  logic       changed_o;

  always #5 clk = ~clk;

  color_sel_encoder #(.DB_CNT(DB)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .btn_next_i (btn_next_i),
    .btn_prev_i (btn_prev_i),
    .load_i     (load_i),
    .code_i     (code_i),
    .code_o     (code_o),
    .changed_o  (changed_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples are recorded per edge since reset. The level the debouncer
  // sees at edge k is the raw value sampled two edges earlier. The debounced state flips at
  // edge k when each of the last DB seen levels differs from it. A press seen at edge k
  // (debounced state rose at edge k-1) moves the code at edge k.
  bit raw_hist [2][MaxE];
  int m_n;
  int m_code;
  bit m_chg;
  bit m_db  [2];
  bit m_dbp [2];

  function automatic bit seen_lvl(input int b, input int k);
    if (k < 3) return 1'b0;
    return raw_hist[b][k-3];
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_code = 0;
    m_chg = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_db[b]  = 1'b0;
      m_dbp[b] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int k;
    int old;
    bit pr [2];
    bit flip;
    k = m_n + 1;
    for (int b = 0; b < 2; b++) pr[b] = m_db[b] && !m_dbp[b];
    old = m_code;
    if (load_i) m_code = int'(code_i);
    else if (pr[0] && !pr[1]) m_code = (m_code + 1) % 4;
    else if (pr[1] && !pr[0]) m_code = (m_code + 3) % 4;
    m_chg = (m_code != old);
    if (m_n < MaxE) begin
      raw_hist[0][m_n] = btn_next_i;
      raw_hist[1][m_n] = btn_prev_i;
    end
    for (int b = 0; b < 2; b++) begin
      flip = 1'b1;
      for (int j = k - int'(DB) + 1; j <= k; j++) begin
        if (j < 1 || seen_lvl(b, j) == m_db[b]) flip = 1'b0;
      end
      m_dbp[b] = m_db[b];
      if (flip) m_db[b] = !m_db[b];
    end
    m_n++;
  endtask

  // One clock edge with the inputs currently driven; compare against the model.
  task automatic step(input string name);
    model_edge();
    @(posedge clk);
    #1;
    check({name, ".code"}, int'(code_o), m_code);
    check({name, ".changed"}, int'(changed_o), int'(m_chg));
  endtask

  // Assert reset for two edges, checking the cleared outputs; release between edges so the
  // next rising edge is edge 1.
  task automatic do_reset(input string name);
    rst_ni = 1'b0;
    #1;
    check({name, ".rst_code"}, int'(code_o), 0);
    check({name, ".rst_changed"}, int'(changed_o), 0);
    repeat (2) @(posedge clk);
    #1;
    check({name, ".rst_code_hold"}, int'(code_o), 0);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic drive(input bit nx, input bit pv, input bit ld, input logic [1:0] ci);
    btn_next_i = nx;
    btn_prev_i = pv;
    load_i     = ld;
    code_i     = ci;
  endtask

  typedef struct {
    string      name;
    bit         nx;
    bit         pv;
    bit         ld;
    logic [1:0] ci;
    int         cyc;
    int         exp_code;
    int         exp_chg;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int chg_seen;
    int rn;
    int rp;

    model_reset();

    // Held press from edge 1: code moves on edge DB+3 only.
    do_reset("hold");
    drive(1'b1, 1'b0, 1'b0, 2'b00);
    for (int k = 1; k <= 17; k++) begin
      step("hold");
      check("hold.code_edge", int'(code_o), (k >= 7) ? 1 : 0);
      check("hold.pulse_edge", int'(changed_o), (k == 7) ? 1 : 0);
    end

    // Phase table: inputs held for cyc edges, then final code and number of pulses seen.
    tbl.push_back('{"glitch", 1, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 0, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 1, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 0, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 1, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 0, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 1, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 0, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 1, 0, 0, 2'd0, 3, 0, 0});
    tbl.push_back('{"glitch", 0, 0, 0, 2'd0, 8, 0, 0});
    tbl.push_back('{"next1", 1, 0, 0, 2'd0, 6, 0, 0});
    tbl.push_back('{"next1", 0, 0, 0, 2'd0, 10, 1, 1});
    tbl.push_back('{"next2", 1, 0, 0, 2'd0, 6, 1, 0});
    tbl.push_back('{"next2", 0, 0, 0, 2'd0, 10, 2, 1});
    tbl.push_back('{"next3", 1, 0, 0, 2'd0, 6, 2, 0});
    tbl.push_back('{"next3", 0, 0, 0, 2'd0, 10, 3, 1});
    tbl.push_back('{"next4", 1, 0, 0, 2'd0, 6, 3, 0});
    tbl.push_back('{"next4", 0, 0, 0, 2'd0, 10, 0, 1});
    tbl.push_back('{"prev", 0, 1, 0, 2'd0, 6, 0, 0});
    tbl.push_back('{"prev", 0, 0, 0, 2'd0, 10, 3, 1});
    tbl.push_back('{"load_same", 0, 0, 1, 2'd3, 1, 3, 0});
    tbl.push_back('{"load_new", 0, 0, 1, 2'd1, 1, 1, 1});
    tbl.push_back('{"both", 1, 1, 0, 2'd0, 16, 1, 0});
    tbl.push_back('{"both", 0, 0, 0, 2'd0, 10, 1, 0});
    tbl.push_back('{"both_ld", 1, 1, 0, 2'd0, 6, 1, 0});
    tbl.push_back('{"both_ld", 1, 1, 1, 2'd2, 1, 2, 1});
    tbl.push_back('{"both_ld", 1, 1, 0, 2'd0, 5, 2, 0});
    tbl.push_back('{"both_ld", 0, 0, 0, 2'd0, 10, 2, 0});

    do_reset("table");
    foreach (tbl[i]) begin
      drive(tbl[i].nx, tbl[i].pv, tbl[i].ld, tbl[i].ci);
      chg_seen = 0;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step(tbl[i].name);
        if (changed_o) chg_seen++;
      end
      check({tbl[i].name, ".end_code"}, int'(code_o), tbl[i].exp_code);
      check({tbl[i].name, ".pulses"}, chg_seen, tbl[i].exp_chg);
    end

    // Reset mid-debounce: partial count discarded, held button re-debounced from zero.
    do_reset("midrst");
    drive(1'b0, 1'b1, 1'b0, 2'b00);
    step("midrst.pre");
    step("midrst.pre");
    do_reset("midrst");
    for (int k = 1; k <= 17; k++) begin
      step("midrst");
      check("midrst.code_edge", int'(code_o), (k >= 7) ? 3 : 0);
      check("midrst.pulse_edge", int'(changed_o), (k == 7) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00);
    repeat (8) step("midrst.rel");

    // Randomized runs of button levels with occasional loads.
    do_reset("rand");
    rn = 0;
    rp = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rn == 0) begin
        btn_next_i = 1'($urandom_range(0, 1));
        rn = int'($urandom_range(1, 12));
      end
      if (rp == 0) begin
        btn_prev_i = 1'($urandom_range(0, 1));
        rp = int'($urandom_range(1, 12));
      end
      load_i = ($urandom_range(0, 19) == 0);
      code_i = 2'($urandom);
      rn--;
      rp--;
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
